// File: rtl/pmci_axi_id_tracker.sv
// Reflects AXI IDs across an ID-less AXI-lite fabric: AW/AR IDs are queued in
// per-channel in-order FIFOs and returned as BID/RID on the matching response.
module pmci_axi_id_tracker #(
   parameter int ID_W  = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_csr,
   input  logic             reset_csr,
   input  logic [ID_W-1:0]  aw_id_i,
   input  logic             aw_valid_i,
   output logic             aw_ready_o,
   output logic             aw_valid_o,
   input  logic             aw_ready_i,
   input  logic             b_valid_i,
   input  logic             b_ready_i,
   output logic [ID_W-1:0]  b_id_o,
   input  logic [ID_W-1:0]  ar_id_i,
   input  logic             ar_valid_i,
   output logic             ar_ready_o,
   output logic             ar_valid_o,
   input  logic             ar_ready_i,
   input  logic             r_valid_i,
   input  logic             r_ready_i,
   output logic [ID_W-1:0]  r_id_o,
   output logic [CNT_W-1:0] wr_outstanding_o,
   output logic [CNT_W-1:0] rd_outstanding_o,
   output logic [1:0]       orphan_err_o,
   input  logic             err_clr_i
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Index 0 is the write channel (AW/B), index 1 the read channel (AR/R).
   logic [ID_W-1:0]  mem [2][DEPTH];
   logic [PTR_W-1:0] wptr [2];
   logic [PTR_W-1:0] rptr [2];
   logic [CNT_W-1:0] cnt  [2];
   logic [ID_W-1:0]  id_in [2];
   logic [1:0]       full;
   logic [1:0]       push;
   logic [1:0]       rsp_hs;
   logic [1:0]       pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Full comes from the registered count only, so a pop cannot unblock issue in its own cycle.
   assign full[0]    = (cnt[0] == CNT_W'(DEPTH));
   assign full[1]    = (cnt[1] == CNT_W'(DEPTH));

   assign aw_ready_o = aw_ready_i & ~full[0];
   assign aw_valid_o = aw_valid_i & ~full[0];
   assign ar_ready_o = ar_ready_i & ~full[1];
   assign ar_valid_o = ar_valid_i & ~full[1];

   assign id_in[0]   = aw_id_i;
   assign id_in[1]   = ar_id_i;
   assign push[0]    = aw_valid_o & aw_ready_i;
   assign push[1]    = ar_valid_o & ar_ready_i;
   assign rsp_hs[0]  = b_valid_i & b_ready_i;
   assign rsp_hs[1]  = r_valid_i & r_ready_i;
   assign pop[0]     = rsp_hs[0] & (cnt[0] != '0);
   assign pop[1]     = rsp_hs[1] & (cnt[1] != '0);

   assign b_id_o     = (cnt[0] != '0) ? mem[0][rptr[0]] : '0;
   assign r_id_o     = (cnt[1] != '0) ? mem[1][rptr[1]] : '0;

   assign wr_outstanding_o = cnt[0];
   assign rd_outstanding_o = cnt[1];

   always_ff @(posedge clk_csr) begin
      if (reset_csr) begin
         for (int c = 0; c < 2; c++) begin
            wptr[c] <= '0;
            rptr[c] <= '0;
            cnt[c]  <= '0;
         end
         orphan_err_o <= '0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
               mem[c][wptr[c]] <= id_in[c];
               wptr[c]         <= ptr_inc(wptr[c]);
            end
            if (pop[c]) rptr[c] <= ptr_inc(rptr[c]);
            if (push[c] && !pop[c]) cnt[c] <= cnt[c] + CNT_W'(1);
            else if (pop[c] && !push[c]) cnt[c] <= cnt[c] - CNT_W'(1);
            // A response with nothing queued is an orphan; setting beats clearing.
            if (rsp_hs[c] && !pop[c]) orphan_err_o[c] <= 1'b1;
            else if (err_clr_i) orphan_err_o[c] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pmci_axi_id_tracker.sv
// Directed bench for pmci_axi_id_tracker with a queue-based reference model
// compared against the DUT every cycle, plus literal spot checks.
module tb_pmci_axi_id_tracker;

   localparam int ID_W  = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk_csr = 1'b0;
   logic             reset_csr;
   logic [ID_W-1:0]  aw_id_i, ar_id_i;
   logic             aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i;
   logic             aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
   logic             b_valid_i, b_ready_i, r_valid_i, r_ready_i;
   logic [ID_W-1:0]  b_id_o, r_id_o;
   logic [CNT_W-1:0] wr_outstanding_o, rd_outstanding_o;
   logic [1:0]       orphan_err_o;
   logic             err_clr_i;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   pmci_axi_id_tracker #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk_csr          (clk_csr),
      .reset_csr        (reset_csr),
      .aw_id_i          (aw_id_i),
      .aw_valid_i       (aw_valid_i),
      .aw_ready_o       (aw_ready_o),
      .aw_valid_o       (aw_valid_o),
      .aw_ready_i       (aw_ready_i),
      .b_valid_i        (b_valid_i),
      .b_ready_i        (b_ready_i),
      .b_id_o           (b_id_o),
      .ar_id_i          (ar_id_i),
      .ar_valid_i       (ar_valid_i),
      .ar_ready_o       (ar_ready_o),
      .ar_valid_o       (ar_valid_o),
      .ar_ready_i       (ar_ready_i),
      .r_valid_i        (r_valid_i),
      .r_ready_i        (r_ready_i),
      .r_id_o           (r_id_o),
      .wr_outstanding_o (wr_outstanding_o),
      .rd_outstanding_o (rd_outstanding_o),
      .orphan_err_o     (orphan_err_o),
      .err_clr_i        (err_clr_i)
   );

   always #5 clk_csr = ~clk_csr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-order ID queues and sticky error bits.
   logic [ID_W-1:0] wq[$];
   logic [ID_W-1:0] rq[$];
   logic [1:0]      m_err;
   bit m_wpush, m_wpop, m_worph, m_rpush, m_rpop, m_rorph;

   always @(posedge clk_csr) begin
      if (reset_csr) begin
         wq.delete();
         rq.delete();
         m_err = 2'b00;
      end else begin
         m_wpush = aw_valid_i && aw_ready_i && (wq.size() < DEPTH);
         m_wpop  = b_valid_i && b_ready_i && (wq.size() > 0);
         m_worph = b_valid_i && b_ready_i && (wq.size() == 0);
         m_rpush = ar_valid_i && ar_ready_i && (rq.size() < DEPTH);
         m_rpop  = r_valid_i && r_ready_i && (rq.size() > 0);
         m_rorph = r_valid_i && r_ready_i && (rq.size() == 0);
         if (m_wpop) void'(wq.pop_front());
         if (m_wpush) wq.push_back(aw_id_i);
         if (m_rpop) void'(rq.pop_front());
         if (m_rpush) rq.push_back(ar_id_i);
         if (m_worph) m_err[0] = 1'b1;
         else if (err_clr_i) m_err[0] = 1'b0;
         if (m_rorph) m_err[1] = 1'b1;
         else if (err_clr_i) m_err[1] = 1'b0;
      end
   end

   always @(negedge clk_csr) begin
      if (chk_en) begin
         check("aw_ready_o", 32'(aw_ready_o), 32'(aw_ready_i && (wq.size() < DEPTH)));
         check("aw_valid_o", 32'(aw_valid_o), 32'(aw_valid_i && (wq.size() < DEPTH)));
         check("ar_ready_o", 32'(ar_ready_o), 32'(ar_ready_i && (rq.size() < DEPTH)));
         check("ar_valid_o", 32'(ar_valid_o), 32'(ar_valid_i && (rq.size() < DEPTH)));
         check("b_id_o", 32'(b_id_o), (wq.size() > 0) ? 32'(wq[0]) : 32'h0);
         check("r_id_o", 32'(r_id_o), (rq.size() > 0) ? 32'(rq[0]) : 32'h0);
         check("wr_outstanding_o", 32'(wr_outstanding_o), 32'(wq.size()));
         check("rd_outstanding_o", 32'(rd_outstanding_o), 32'(rq.size()));
         check("orphan_err_o", 32'(orphan_err_o), 32'(m_err));
      end
   end

   task automatic cyc();
      @(posedge clk_csr);
      #1;
   endtask

   initial begin
      reset_csr  = 1'b1;
      aw_id_i    = '0; ar_id_i    = '0;
      aw_valid_i = 1'b0; ar_valid_i = 1'b0;
      aw_ready_i = 1'b0; ar_ready_i = 1'b0;
      b_valid_i  = 1'b0; r_valid_i  = 1'b0;
      b_ready_i  = 1'b1; r_ready_i  = 1'b1;
      err_clr_i  = 1'b0;
      cyc();
      cyc();
      reset_csr = 1'b0;
      chk_en    = 1'b1;

      // Reset state
      check("rst_wr_cnt", 32'(wr_outstanding_o), 0);
      check("rst_rd_cnt", 32'(rd_outstanding_o), 0);
      check("rst_err", 32'(orphan_err_o), 0);
      check("rst_b_id", 32'(b_id_o), 0);
      check("rst_aw_ready", 32'(aw_ready_o), 0);
      aw_ready_i = 1'b1;
      ar_ready_i = 1'b1;
      #1;
      check("rst_aw_ready_follow", 32'(aw_ready_o), 1);

      // Three writes then three B responses in order
      aw_valid_i = 1'b1;
      aw_id_i = 8'h11; cyc(); check("t1_cnt1", 32'(wr_outstanding_o), 1);
      check("t1_head", 32'(b_id_o), 32'h11);
      aw_id_i = 8'h22; cyc(); check("t1_cnt2", 32'(wr_outstanding_o), 2);
      aw_id_i = 8'h33; cyc(); check("t1_cnt3", 32'(wr_outstanding_o), 3);
      aw_valid_i = 1'b0;
      b_valid_i  = 1'b1;
      check("t1_bid0", 32'(b_id_o), 32'h11); cyc();
      check("t1_cnt_d2", 32'(wr_outstanding_o), 2);
      check("t1_bid1", 32'(b_id_o), 32'h22); cyc();
      check("t1_cnt_d1", 32'(wr_outstanding_o), 1);
      check("t1_bid2", 32'(b_id_o), 32'h33); cyc();
      check("t1_cnt_d0", 32'(wr_outstanding_o), 0);
      check("t1_bid_empty", 32'(b_id_o), 0);
      b_valid_i = 1'b0;

      // Fill to DEPTH, fifth AW blocked; pop in same cycle does not unblock
      aw_valid_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         aw_id_i = 8'(i);
         cyc();
      end
      aw_id_i = 8'h05;
      #1;
      check("t2_full_ready", 32'(aw_ready_o), 0);
      check("t2_full_valid", 32'(aw_valid_o), 0);
      check("t2_full_cnt", 32'(wr_outstanding_o), 4);
      cyc();
      check("t2_held_cnt", 32'(wr_outstanding_o), 4);
      b_valid_i = 1'b1;
      check("t2_bid", 32'(b_id_o), 32'h01);
      cyc();
      check("t2_after_pop_cnt", 32'(wr_outstanding_o), 3);
      b_valid_i = 1'b0;
      #1;
      check("t2_unblocked", 32'(aw_ready_o), 1);
      cyc();
      check("t2_refill_cnt", 32'(wr_outstanding_o), 4);
      aw_valid_i = 1'b0;
      b_valid_i  = 1'b1;
      repeat (4) cyc();
      b_valid_i = 1'b0;
      check("t2_drained", 32'(wr_outstanding_o), 0);

      // Simultaneous push and pop at count 2 across pointer wrap
      aw_valid_i = 1'b1;
      aw_id_i = 8'h40; cyc();
      aw_id_i = 8'h41; cyc();
      b_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         aw_id_i = 8'(8'h42 + i);
         check("t3_head", 32'(b_id_o), 32'(8'h40 + i));
         cyc();
         check("t3_cnt", 32'(wr_outstanding_o), 2);
      end
      aw_valid_i = 1'b0;
      check("t3_tail0", 32'(b_id_o), 32'h48); cyc();
      check("t3_tail1", 32'(b_id_o), 32'h49); cyc();
      b_valid_i = 1'b0;
      check("t3_empty", 32'(wr_outstanding_o), 0);

      // Orphans: B on empty, clear, push+orphan at count 0, set-wins, R orphan
      b_valid_i = 1'b1;
      check("t4_orph_bid", 32'(b_id_o), 0);
      cyc();
      b_valid_i = 1'b0;
      check("t4_err_b", 32'(orphan_err_o), 32'b01);
      err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
      check("t4_clr_b", 32'(orphan_err_o), 0);
      aw_valid_i = 1'b1; aw_id_i = 8'h77; b_valid_i = 1'b1;
      check("t4_pp0_bid", 32'(b_id_o), 0);
      cyc();
      aw_valid_i = 1'b0; b_valid_i = 1'b0;
      check("t4_pp0_cnt", 32'(wr_outstanding_o), 1);
      check("t4_pp0_err", 32'(orphan_err_o), 32'b01);
      check("t4_pp0_head", 32'(b_id_o), 32'h77);
      err_clr_i = 1'b1; b_valid_i = 1'b1; cyc();
      check("t4_clr_pop", 32'(orphan_err_o), 0);
      cyc();
      check("t4_set_wins", 32'(orphan_err_o), 32'b01);
      b_valid_i = 1'b0; cyc(); err_clr_i = 1'b0;
      check("t4_clr2", 32'(orphan_err_o), 0);
      r_valid_i = 1'b1; cyc(); r_valid_i = 1'b0;
      check("t4_err_r", 32'(orphan_err_o), 32'b10);
      err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
      check("t4_clr_r", 32'(orphan_err_o), 0);

      // Interleaved reads and writes
      ar_valid_i = 1'b1; ar_id_i = 8'hA0; cyc(); ar_valid_i = 1'b0;
      aw_valid_i = 1'b1; aw_id_i = 8'h05; cyc(); aw_valid_i = 1'b0;
      ar_valid_i = 1'b1; ar_id_i = 8'hA1; cyc(); ar_valid_i = 1'b0;
      check("t5_rd_cnt", 32'(rd_outstanding_o), 2);
      r_valid_i = 1'b1; check("t5_rid0", 32'(r_id_o), 32'hA0); cyc(); r_valid_i = 1'b0;
      b_valid_i = 1'b1; check("t5_bid", 32'(b_id_o), 32'h05); cyc(); b_valid_i = 1'b0;
      r_valid_i = 1'b1; check("t5_rid1", 32'(r_id_o), 32'hA1); cyc(); r_valid_i = 1'b0;
      check("t5_rd_empty", 32'(rd_outstanding_o), 0);
      check("t5_wr_empty", 32'(wr_outstanding_o), 0);

      // Reset with reads outstanding, then an orphan R
      ar_valid_i = 1'b1;
      ar_id_i = 8'hC1; cyc();
      ar_id_i = 8'hC2; cyc();
      ar_id_i = 8'hC3; cyc();
      ar_valid_i = 1'b0;
      check("t6_rd_cnt3", 32'(rd_outstanding_o), 3);
      reset_csr = 1'b1; cyc(); reset_csr = 1'b0;
      check("t6_rst_cnt", 32'(rd_outstanding_o), 0);
      check("t6_rst_rid", 32'(r_id_o), 0);
      r_valid_i = 1'b1; cyc(); r_valid_i = 1'b0;
      check("t6_orphan_r", 32'(orphan_err_o[1]), 1);
      cyc();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
